axi_burst_test_master: RTL and testbench

AXI3 initiator that exercises an SRAM slave on the MUNOC fabric by issuing incrementing-address write bursts of a generated pattern, or read bursts whose data it checks against that pattern. One command runs at a time, and at most one burst is outstanding. The block sits on a master port of the network, or connects directly to the SRAM controller's rx* ports, and is driven by a local control register file.

---
 rtl/axi_burst_test_master.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_burst_test_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_test_master.sv
// AXI3 burst test initiator: writes an incrementing seed pattern to memory or reads it back and
// counts mismatches. One burst in flight at a time, and each burst stays inside a 4 KB page.
module axi_burst_test_master #(
    parameter int BW_ADDR       = 32,
    parameter int BW_DATA       = 32,
    parameter int BW_AXI_TID    = 4,
    parameter int TID           = 0,
    parameter int MAX_BURST_LEN = 16,
    parameter int BW_COUNT      = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [BW_ADDR-1:0]    cmd_addr,
    input  logic [BW_COUNT-1:0]   cmd_num_word,
    input  logic [BW_DATA-1:0]    cmd_seed,
    output logic                  busy,
    output logic                  done,
    output logic [BW_COUNT-1:0]   error_count,
    output logic                  resp_error,

    output logic [BW_AXI_TID-1:0] sxawid,
    output logic [BW_ADDR-1:0]    sxawaddr,
    output logic [3:0]            sxawlen,
    output logic [2:0]            sxawsize,
    output logic [1:0]            sxawburst,
    output logic                  sxawvalid,
    input  logic                  sxawready,

    output logic [BW_AXI_TID-1:0] sxwid,
    output logic [BW_DATA-1:0]    sxwdata,
    output logic [BW_DATA/8-1:0]  sxwstrb,
    output logic                  sxwlast,
    output logic                  sxwvalid,
    input  logic                  sxwready,

    input  logic [BW_AXI_TID-1:0] sxbid,
    input  logic [1:0]            sxbresp,
    input  logic                  sxbvalid,
    output logic                  sxbready,

    output logic [BW_AXI_TID-1:0] sxarid,
    output logic [BW_ADDR-1:0]    sxaraddr,
    output logic [3:0]            sxarlen,
    output logic [2:0]            sxarsize,
    output logic [1:0]            sxarburst,
    output logic                  sxarvalid,
    input  logic                  sxarready,

    input  logic [BW_AXI_TID-1:0] sxrid,
    input  logic [BW_DATA-1:0]    sxrdata,
    input  logic [1:0]            sxrresp,
    input  logic                  sxrlast,
    input  logic                  sxrvalid,
    output logic                  sxrready
);

    localparam int BYTES   = BW_DATA / 8;
    localparam int SIZE    = $clog2(BYTES);
    localparam int BW_BEAT = 5;

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t state, state_nxt;

    logic [BW_ADDR-1:0]  addr_q;
    logic [BW_COUNT-1:0] remaining_q;
    logic [BW_COUNT-1:0] idx_q;
    logic [BW_DATA-1:0]  seed_q;
    logic [BW_BEAT-1:0]  beat_q;

    logic [12:0]         words_4k;
    logic [BW_BEAT-1:0]  rem_lim;
    logic [BW_BEAT-1:0]  beats;
    logic [BW_DATA-1:0]  pattern;
    logic                cmd_acc, aw_hs, w_hs, w_last, b_hs, ar_hs, r_hs, r_end;
    logic                burst_end, last_burst;

    // Response IDs are not checked; only one burst is ever outstanding.
    logic unused_ids;
    assign unused_ids = &{1'b0, sxbid, sxrid};

    // Burst size is derived from the live address and remaining count; both stay
    // constant while a burst is in flight, so AxLEN and the final update agree.
    always_comb begin
        words_4k = (13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE;
        rem_lim  = (remaining_q > BW_COUNT'(MAX_BURST_LEN)) ? BW_BEAT'(MAX_BURST_LEN)
                                                            : BW_BEAT'(remaining_q);
        beats    = (13'(rem_lim) > words_4k) ? BW_BEAT'(words_4k) : rem_lim;
    end

    assign pattern    = seed_q + BW_DATA'(idx_q);
    assign cmd_acc    = cmd_valid && (state == S_IDLE);
    assign aw_hs      = (state == S_AW) && sxawready;
    assign w_hs       = (state == S_W)  && sxwready;
    assign w_last     = (beat_q == beats - BW_BEAT'(1));
    assign b_hs       = (state == S_B)  && sxbvalid;
    assign ar_hs      = (state == S_AR) && sxarready;
    assign r_hs       = (state == S_R)  && sxrvalid;
    assign r_end      = r_hs && sxrlast;
    assign burst_end  = b_hs || r_end;
    assign last_burst = (remaining_q == BW_COUNT'(beats));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cmd_acc) begin
                if (cmd_num_word == '0) state_nxt = S_DONE;
                else if (cmd_write)     state_nxt = S_AW;
                else                    state_nxt = S_AR;
            end
            S_AW:   if (aw_hs)           state_nxt = S_W;
            S_W:    if (w_hs && w_last)  state_nxt = S_B;
            S_B:    if (b_hs)            state_nxt = last_burst ? S_DONE : S_AW;
            S_AR:   if (ar_hs)           state_nxt = S_R;
            S_R:    if (r_end)           state_nxt = last_burst ? S_DONE : S_AR;
            S_DONE:                      state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            seed_q      <= '0;
            beat_q      <= '0;
            error_count <= '0;
            resp_error  <= 1'b0;
        end else begin
            if (cmd_acc) begin
                addr_q      <= cmd_addr;
                remaining_q <= cmd_num_word;
                idx_q       <= '0;
                seed_q      <= cmd_seed;
                beat_q      <= '0;
                error_count <= '0;
                resp_error  <= 1'b0;
            end
            if (aw_hs) beat_q <= '0;
            if (w_hs) begin
                idx_q  <= idx_q + BW_COUNT'(1);
                beat_q <= beat_q + BW_BEAT'(1);
            end
            if (b_hs && sxbresp != 2'b00) resp_error <= 1'b1;
            if (r_hs) begin
                idx_q <= idx_q + BW_COUNT'(1);
                if (sxrresp != 2'b00) resp_error <= 1'b1;
                if (sxrdata != pattern && error_count != '1)
                    error_count <= error_count + BW_COUNT'(1);
            end
            if (burst_end) begin
                addr_q      <= addr_q + (BW_ADDR'(beats) << SIZE);
                remaining_q <= remaining_q - BW_COUNT'(beats);
            end
        end
    end

    // Address and data buses read zero outside their channel's state.
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);

        sxawid    = '0;
        sxawaddr  = '0;
        sxawlen   = '0;
        sxawsize  = '0;
        sxawburst = '0;
        sxawvalid = 1'b0;
        sxwid     = '0;
        sxwdata   = '0;
        sxwstrb   = '0;
        sxwlast   = 1'b0;
        sxwvalid  = 1'b0;
        sxbready  = 1'b0;
        sxarid    = '0;
        sxaraddr  = '0;
        sxarlen   = '0;
        sxarsize  = '0;
        sxarburst = '0;
        sxarvalid = 1'b0;
        sxrready  = 1'b0;

        case (state)
            S_AW: begin
                sxawvalid = 1'b1;
                sxawid    = BW_AXI_TID'(TID);
                sxawaddr  = addr_q;
                sxawlen   = 4'(beats - BW_BEAT'(1));
                sxawsize  = 3'(SIZE);
                sxawburst = 2'b01;
            end
            S_W: begin
                sxwvalid = 1'b1;
                sxwid    = BW_AXI_TID'(TID);
                sxwdata  = pattern;
                sxwstrb  = '1;
                sxwlast  = w_last;
            end
            S_B: sxbready = 1'b1;
            S_AR: begin
                sxarvalid = 1'b1;
                sxarid    = BW_AXI_TID'(TID);
                sxaraddr  = addr_q;
                sxarlen   = 4'(beats - BW_BEAT'(1));
                sxarsize  = 3'(SIZE);
                sxarburst = 2'b01;
            end
            S_R: sxrready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_burst_test_master.sv
// Bench for axi_burst_test_master: an AXI3 memory slave with optional random stalls, and a
// reference model that plans bursts and predicts memory contents and mismatch counts.
module tb_axi_burst_test_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_num_word;
    logic [31:0] cmd_seed;
    logic        busy, done;
    logic [15:0] error_count;
    logic        resp_error;
    logic [3:0]  sxawid, sxwid, sxbid, sxarid, sxrid;
    logic [31:0] sxawaddr, sxaraddr, sxwdata, sxrdata;
    logic [3:0]  sxawlen, sxarlen, sxwstrb;
    logic [2:0]  sxawsize, sxarsize;
    logic [1:0]  sxawburst, sxarburst, sxbresp, sxrresp;
    logic        sxawvalid, sxawready, sxwlast, sxwvalid, sxwready;
    logic        sxbvalid, sxbready, sxarvalid, sxarready, sxrlast, sxrvalid, sxrready;

    axi_burst_test_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_num_word(cmd_num_word), .cmd_seed(cmd_seed),
        .busy(busy), .done(done), .error_count(error_count), .resp_error(resp_error),
        .sxawid(sxawid), .sxawaddr(sxawaddr), .sxawlen(sxawlen), .sxawsize(sxawsize),
        .sxawburst(sxawburst), .sxawvalid(sxawvalid), .sxawready(sxawready),
        .sxwid(sxwid), .sxwdata(sxwdata), .sxwstrb(sxwstrb), .sxwlast(sxwlast),
        .sxwvalid(sxwvalid), .sxwready(sxwready),
        .sxbid(sxbid), .sxbresp(sxbresp), .sxbvalid(sxbvalid), .sxbready(sxbready),
        .sxarid(sxarid), .sxaraddr(sxaraddr), .sxarlen(sxarlen), .sxarsize(sxarsize),
        .sxarburst(sxarburst), .sxarvalid(sxarvalid), .sxarready(sxarready),
        .sxrid(sxrid), .sxrdata(sxrdata), .sxrresp(sxrresp), .sxrlast(sxrlast),
        .sxrvalid(sxrvalid), .sxrready(sxrready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] addr; logic [3:0] len; } burst_t;
    burst_t exp_q[$];
    logic [31:0] mem     [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a >> 2) ? mem[a >> 2] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
    endfunction

    task automatic plan(input logic [31:0] a, input int n, output int cnt);
        int rem, b, room;
        logic [31:0] p;
        rem = n; p = a; cnt = 0;
        while (rem > 0) begin
            room = (4096 - int'(p % 4096)) / 4;
            b = (rem > 16) ? 16 : rem;
            if (b > room) b = room;
            exp_q.push_back('{addr: p, len: 4'(b - 1)});
            p += 32'(b * 4);
            rem -= b;
            cnt++;
        end
    endtask

    function automatic int exp_err(input logic [31:0] a, input int n, input logic [31:0] s);
        int c;
        logic [31:0] e;
        c = 0;
        for (int i = 0; i < n; i++) begin
            e = s + 32'(i);
            if (ref_rd(a + 32'(i * 4)) !== e) c++;
        end
        return (c > 65535) ? 65535 : c;
    endfunction

    // ---------------- slave ----------------
    bit          stall_en, bresp_err_first, rresp_err_first;
    logic [31:0] cur_seed;
    int          w_idx, aw_cnt, ar_cnt, b_cnt, r_hs_cnt, last_hs_cyc;
    bit          any_valid;

    initial begin
        bit          aw_pend, b_pend, ar_pend, aw_stall, w_stall, exp_w, exp_b, exp_aw, exp_ar;
        logic [31:0] aw_addr, r_addr, aw_prev_addr, w_prev_data, wexp;
        logic [3:0]  aw_len, r_len, aw_prev_len;
        logic        w_prev_last;
        int          w_beat, r_beat;
        burst_t      eb;
        {aw_pend, b_pend, ar_pend, aw_stall, w_stall, exp_w, exp_b, exp_aw, exp_ar} = '0;
        {sxawready, sxwready, sxbvalid, sxarready, sxrvalid, sxrlast} = '0;
        sxbid = '0; sxbresp = '0; sxrid = '0; sxrdata = '0; sxrresp = '0;
        w_beat = 0; r_beat = 0; aw_addr = '0; aw_len = '0; r_addr = '0; r_len = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                {aw_pend, b_pend, ar_pend, aw_stall, w_stall, exp_w, exp_b, exp_aw, exp_ar} = '0;
                {sxawready, sxwready, sxbvalid, sxarready, sxrvalid, sxrlast} = '0;
                sxrdata = '0; sxrresp = '0; sxbresp = '0;
                continue;
            end
            if (aw_stall) chk("aw_stable", {sxawvalid, sxawaddr, sxawlen}, {1'b1, aw_prev_addr, aw_prev_len});
            if (w_stall)  chk("w_stable", {sxwvalid, sxwlast, sxwdata}, {1'b1, w_prev_last, w_prev_data});
            if (exp_w)  chk("w_latency", sxwvalid, 1);
            if (exp_b)  chk("b_latency", sxbready, 1);
            if (exp_aw) chk("aw_relaunch", sxawvalid, 1);
            if (exp_ar) chk("ar_relaunch", sxarvalid, 1);
            {exp_w, exp_b, exp_aw, exp_ar} = '0;
            any_valid |= sxawvalid | sxwvalid | sxarvalid;

            sxawready = !aw_pend && !b_pend && (!stall_en || $urandom_range(0, 1) == 1);
            sxwready  = aw_pend && (!stall_en || $urandom_range(0, 2) != 0);
            sxbvalid  = b_pend && (sxbvalid || !stall_en || $urandom_range(0, 1) == 1);
            sxbresp   = (bresp_err_first && b_cnt == 0) ? 2'b10 : 2'b00;
            sxarready = !ar_pend && (!stall_en || $urandom_range(0, 1) == 1);
            sxrvalid  = ar_pend && (sxrvalid || !stall_en || $urandom_range(0, 1) == 1);
            sxrdata   = ar_pend ? mem_rd(r_addr + 32'(r_beat * 4)) : 32'h0;
            sxrlast   = ar_pend && (r_beat == int'(r_len));
            sxrresp   = (rresp_err_first && r_hs_cnt == 0) ? 2'b10 : 2'b00;

            if (sxawvalid && sxawready) begin
                if (exp_q.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    eb = exp_q.pop_front();
                    chk("aw_addr", sxawaddr, eb.addr);
                    chk("aw_len", sxawlen, eb.len);
                end
                chk("aw_fixed", {sxawid, sxawsize, sxawburst}, {4'd0, 3'd2, 2'b01});
                chk("aw_4k", (int'(sxawaddr % 4096) + (int'(sxawlen) + 1) * 4) <= 4096, 1);
                aw_pend = 1; aw_addr = sxawaddr; aw_len = sxawlen; w_beat = 0; exp_w = 1; aw_cnt++;
            end
            if (sxwvalid && sxwready) begin
                wexp = cur_seed + 32'(w_idx);
                chk("w_data", sxwdata, wexp);
                chk("w_last", sxwlast, w_beat == int'(aw_len));
                chk("w_strb_id", {sxwstrb, sxwid}, {4'hf, 4'h0});
                mem[(aw_addr >> 2) + 32'(w_beat)] = sxwdata;
                w_idx++;
                if (w_beat == int'(aw_len)) begin aw_pend = 0; b_pend = 1; exp_b = 1; end
                w_beat++;
            end
            if (sxbvalid && sxbready) begin
                b_pend = 0; b_cnt++; last_hs_cyc = cyc;
                exp_aw = (exp_q.size() > 0);
            end
            if (sxarvalid && sxarready) begin
                if (exp_q.size() == 0) chk("ar_unexpected", 1, 0);
                else begin
                    eb = exp_q.pop_front();
                    chk("ar_addr", sxaraddr, eb.addr);
                    chk("ar_len", sxarlen, eb.len);
                end
                chk("ar_fixed", {sxarid, sxarsize, sxarburst}, {4'd0, 3'd2, 2'b01});
                ar_pend = 1; r_addr = sxaraddr; r_len = sxarlen; r_beat = 0; ar_cnt++;
            end
            if (sxrvalid && sxrready) begin
                r_hs_cnt++;
                if (sxrlast) begin
                    ar_pend = 0; last_hs_cyc = cyc;
                    exp_ar = (exp_q.size() > 0);
                end
                r_beat++;
            end
            aw_stall = sxawvalid && !sxawready;
            aw_prev_addr = sxawaddr; aw_prev_len = sxawlen;
            w_stall = sxwvalid && !sxwready;
            w_prev_data = sxwdata; w_prev_last = sxwlast;
        end
    end

    // ---------------- command driver ----------------
    task automatic run_cmd(input bit wr, input logic [31:0] a, input int n, input logic [31:0] seed);
        int t, nb, bad;
        logic [15:0] exp_e;
        bit exp_re;
        logic [31:0] e;
        plan(a, n, nb);
        cur_seed = seed; w_idx = 0; aw_cnt = 0; ar_cnt = 0; b_cnt = 0; r_hs_cnt = 0;
        last_hs_cyc = -100; any_valid = 0;
        exp_e  = wr ? 16'd0 : 16'(exp_err(a, n, seed));
        exp_re = (n > 0) && ((wr && bresp_err_first) || (!wr && rresp_err_first));
        @(negedge clk);
        t = 0;
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_num_word = 16'(n); cmd_seed = seed;
        @(negedge clk);
        cmd_valid = 0; cmd_addr = $urandom; cmd_seed = $urandom; cmd_num_word = 16'($urandom);
        chk("busy_on_accept", {busy, cmd_ready}, 2'b10);
        chk("status_cleared", {resp_error, error_count}, 17'h0);
        if (n == 0) chk("zero_done_lat", done, 1);
        else        chk("first_axvalid", wr ? sxawvalid : sxarvalid, 1);
        t = 0;
        while (!done && t < 5000) begin @(negedge clk); t++; end
        chk("done_seen", done, 1);
        if (n > 0) chk("done_latency", 64'(cyc - last_hs_cyc), 1);
        chk("done_cmd_ready", cmd_ready, 0);
        chk("bursts_left", exp_q.size(), 0);
        chk("burst_count", wr ? b_cnt : ar_cnt, nb);
        exp_q.delete();
        @(negedge clk);
        chk("done_one_pulse", {done, busy, cmd_ready}, 3'b001);
        chk("error_count", error_count, exp_e);
        chk("resp_error", resp_error, exp_re);
        if (n == 0) chk("zero_no_valid", any_valid, 0);
        if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[(a >> 2) + 32'(i)] = seed + 32'(i);
            bad = 0;
            for (int i = 0; i < n; i++) begin
                e = ref_rd(a + 32'(i * 4));
                if (mem_rd(a + 32'(i * 4)) !== e) bad++;
            end
            chk("mem_contents", bad, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {cmd_ready, busy, done, resp_error, error_count}, {4'b1000, 16'h0});
        chk({tag, "_valid"}, {sxawvalid, sxwvalid, sxbready, sxarvalid, sxrready}, 5'b0);
        chk({tag, "_bus"}, {sxawaddr, sxaraddr}, 64'h0);
        chk({tag, "_data"}, {sxwdata, sxwlast, sxawlen, sxarlen}, 41'h0);
    endtask

    initial begin
        int t, dummy;
        logic [31:0] a, s, lw_a, lw_s;
        int n, lw_n;
        bit wr;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_num_word = '0; cmd_seed = '0;
        stall_en = 0; bresp_err_first = 0; rresp_err_first = 0;
        cur_seed = '0; w_idx = 0; aw_cnt = 0; ar_cnt = 0; b_cnt = 0; r_hs_cnt = 0;
        last_hs_cyc = 0; any_valid = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 0;

        run_cmd(1, 32'h0000_0100, 20, 32'hA5A5_0000);
        chk("two_aw_bursts", aw_cnt, 2);
        run_cmd(0, 32'h0000_0100, 20, 32'hA5A5_0000);
        run_cmd(0, 32'h0000_0100, 20, 32'hA5A5_0001);
        chk("all_mismatch", error_count, 20);
        run_cmd(1, 32'h0000_0FF0, 8, 32'h1234_5678);
        chk("crossing_bursts", aw_cnt, 2);

        stall_en = 1;
        run_cmd(1, 32'h0000_2F80, 37, 32'hDEAD_0000);
        run_cmd(0, 32'h0000_2F80, 37, 32'hDEAD_0000);
        run_cmd(0, 32'h0000_2F84, 30, 32'hDEAD_0000);
        stall_en = 0;

        bresp_err_first = 1;
        run_cmd(1, 32'h0000_3000, 20, 32'h0BAD_0000);
        chk("bresp_second_burst", aw_cnt, 2);
        bresp_err_first = 0;
        rresp_err_first = 1;
        run_cmd(0, 32'h0000_3000, 20, 32'h0BAD_0000);
        rresp_err_first = 0;
        run_cmd(1, 32'h0000_3100, 4, 32'h0000_00FF);
        run_cmd(1, 32'h0000_4000, 0, 32'h5555_5555);

        lw_a = 32'h0000_0100; lw_n = 20; lw_s = 32'hA5A5_0000;
        for (int k = 0; k < 14; k++) begin
            stall_en = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 1) == 1);
            a = (32'($urandom_range(0, 7)) << 12) + (32'($urandom_range(0, 1023)) << 2);
            n = $urandom_range(0, 40);
            s = $urandom;
            if (!wr && $urandom_range(0, 1) == 1) begin a = lw_a; n = lw_n; s = lw_s; end
            if (wr) begin lw_a = a; lw_n = n; lw_s = s; end
            run_cmd(wr, a, n, s);
        end
        stall_en = 0;

        // Reset in the middle of a 16-beat read.
        plan(32'h0000_0100, 16, dummy);
        cur_seed = 32'hA5A5_0000; r_hs_cnt = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0000_0100; cmd_num_word = 16'd16;
        cmd_seed = 32'hA5A5_0000;
        @(negedge clk);
        cmd_valid = 0;
        t = 0;
        while (r_hs_cnt < 5 && t < 200) begin @(negedge clk); t++; end
        chk("mid_read_reached", r_hs_cnt >= 5, 1);
        chk("mid_read_busy", {busy, sxrready}, 2'b11);
        @(posedge clk); #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1 rst = 0;
        exp_q.delete();
        run_cmd(0, 32'h0000_0100, 20, 32'hA5A5_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
